// File: rtl/expr_lane_pkg.sv
// expr_lane_pkg: shared definitions for the multi-lane expression pipeline.
//   OP_W       - width of the opcode field
//   DEF_LANES  - default lane count
//   DEF_W      - default lane width
//   op_e       - opcode encoding, ADD..MUL = 0..7
package expr_lane_pkg;

  localparam int OP_W      = 3;
  localparam int DEF_LANES = 4;
  localparam int DEF_W     = 6;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_XNOR = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_LT   = 3'd6,
    OP_MUL  = 3'd7
  } op_e;

endpackage

// File: rtl/expr_lane_alu.sv
// expr_lane_alu: combinational single-lane evaluator.
//   a, b       - W-bit operands (b is always an unsigned amount for shifts)
//   op         - opcode
//   is_signed  - 1: two's-complement operands, 0: unsigned
//   y          - W-bit truncated result
//   ovf        - overflow flag (ADD/SUB/MUL only)
module expr_lane_alu
  import expr_lane_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          op,
  input  logic         is_signed,
  output logic [W-1:0] y,
  output logic         ovf
);

  localparam logic [W-1:0] SHAMT_LIM = W'(W);

  logic         sa, sb;
  logic [W:0]   a_x, b_x, sum, diff;
  logic [2*W-1:0] a_m, b_m, prod;

  // Extension bit is the sign bit only in signed mode
  assign sa = is_signed & a[W-1];
  assign sb = is_signed & b[W-1];

  always_comb begin
    a_x  = {sa, a};
    b_x  = {sb, b};
    a_m  = {{W{sa}}, a};
    b_m  = {{W{sb}}, b};
    sum  = a_x + b_x;
    diff = a_x - b_x;
    prod = a_m * b_m;
    y    = '0;
    ovf  = 1'b0;
    unique case (op)
      OP_ADD: begin
        y   = sum[W-1:0];
        // Signed: top two bits disagree; unsigned: carry out
        ovf = is_signed ? (sum[W] ^ sum[W-1]) : sum[W];
      end
      OP_SUB: begin
        y   = diff[W-1:0];
        // Unsigned: bit W set means the difference went negative (borrow)
        ovf = is_signed ? (diff[W] ^ diff[W-1]) : diff[W];
      end
      OP_AND:  y = a & b;
      OP_XNOR: y = ~(a ^ b);
      OP_SHL:  y = (b >= SHAMT_LIM) ? '0 : (a << b);
      OP_SHR: begin
        if (b >= SHAMT_LIM) y = {W{sa}};
        else if (is_signed) y = $signed(a) >>> b;
        else                y = a >> b;
      end
      OP_LT: begin
        y = {{(W-1){1'b0}}, (is_signed ? ($signed(a) < $signed(b)) : (a < b))};
      end
      OP_MUL: begin
        y   = prod[W-1:0];
        // Signed product fits only if the upper W+1 bits are a pure sign extension
        ovf = is_signed ? (prod[2*W-1:W-1] != {(W+1){prod[W-1]}}) : (|prod[2*W-1:W]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/expr_lane_pipe.sv
// expr_lane_pipe: two-stage valid/ready pipeline evaluating LANES lanes per transaction.
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_ready     - input handshake
//   in_a, in_b            - packed operands, lane i at [i*W +: W]
//   in_op, in_signed      - shared opcode and signedness
//   in_acc                - per-lane accumulator replaces A
//   acc_clr               - synchronous clear of all accumulators
//   out_valid/out_ready   - output handshake
//   out_y, out_ovf        - packed results and per-lane overflow
module expr_lane_pipe
  import expr_lane_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int W     = DEF_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic [OP_W-1:0]    in_op,
  input  logic               in_signed,
  input  logic               in_acc,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_y,
  output logic [LANES-1:0]   out_ovf
);

  localparam int BW = LANES * W;

  logic           en;
  logic           v1, v2;
  logic [BW-1:0]  a1, b1;
  op_e            op1;
  logic           sgn1, acc1;
  logic [BW-1:0]  y2;
  logic [LANES-1:0] ovf2;
  logic [W-1:0]   acc [LANES];
  logic [BW-1:0]  lane_y;
  logic [LANES-1:0] lane_ovf;

  // A stalled output freezes the whole pipe, even when stage 1 is empty
  assign en       = !(v2 && !out_ready);
  assign in_ready = en;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] a_sel;
    assign a_sel = acc1 ? acc[i] : a1[i*W +: W];

    expr_lane_alu #(
      .W(W)
    ) u_alu (
      .a        (a_sel),
      .b        (b1[i*W +: W]),
      .op       (op1),
      .is_signed(sgn1),
      .y        (lane_y[i*W +: W]),
      .ovf      (lane_ovf[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      op1  <= OP_ADD;
      sgn1 <= 1'b0;
      acc1 <= 1'b0;
      y2   <= '0;
      ovf2 <= '0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1   <= in_a;
        b1   <= in_b;
        op1  <= op_e'(in_op);
        sgn1 <= in_signed;
        acc1 <= in_acc;
      end
      v2 <= v1;
      if (v1) begin
        y2   <= lane_y;
        ovf2 <= lane_ovf;
      end
    end
  end

  // Accumulators update on the same edge a transaction enters stage 2, so the
  // next transaction in stage 1 sees the new value without a bubble. acc_clr
  // is an explicit command and wins over the write, stalled or not.
  always_ff @(posedge clk) begin
    if (reset || acc_clr) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (en && v1 && acc1) begin
      for (int i = 0; i < LANES; i++) acc[i] <= lane_y[i*W +: W];
    end
  end

  assign out_valid = v2;
  assign out_y     = y2;
  assign out_ovf   = ovf2;

endmodule

// File: tb/tb_expr_lane_pipe.sv
module tb_expr_lane_pipe;

  localparam int LANES = 4;
  localparam int W     = 6;
  localparam int BW    = LANES * W;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [BW-1:0]    in_a;
  logic [BW-1:0]    in_b;
  logic [2:0]       in_op;
  logic             in_signed;
  logic             in_acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [BW-1:0]    out_y;
  logic [LANES-1:0] out_ovf;

  expr_lane_pipe #(
    .LANES(LANES),
    .W    (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .in_signed(in_signed),
    .in_acc   (in_acc),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    int            op;
    bit            sgn;
    bit            acc;
  } txn_t;

  typedef struct {
    logic [BW-1:0]    y;
    logic [LANES-1:0] ovf;
  } exp_t;

  txn_t         pend[$];
  exp_t         sb[$];
  logic [W-1:0] macc[LANES];
  logic [W-1:0] obs_y[$];
  logic         obs_ovf[$];
  int           obs_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference lane: operands interpreted as integers, result reduced modulo 2^W.
  function automatic void ref_lane(input logic [W-1:0] a, input logic [W-1:0] b, input int op,
                                   input bit sgn, output logic [W-1:0] y, output bit ovf);
    longint m, va, vb, r, lo, hi;
    logic [W-1:0] t;
    m   = longint'(1) << W;
    va  = (sgn && a[W-1]) ? longint'(a) - m : longint'(a);
    vb  = (sgn && b[W-1]) ? longint'(b) - m : longint'(b);
    lo  = sgn ? -(m / 2) : 0;
    hi  = sgn ? (m / 2 - 1) : (m - 1);
    ovf = 1'b0;
    r   = 0;
    case (op)
      0: begin r = va + vb; ovf = (r < lo) || (r > hi); end
      1: begin r = va - vb; ovf = (r < lo) || (r > hi); end
      2: begin t = a & b; r = longint'(t); end
      3: begin t = ~(a ^ b); r = longint'(t); end
      4: r = (int'(b) >= W) ? 0 : (longint'(a) << b);
      5: begin
        if (int'(b) >= W) r = (sgn && va < 0) ? -1 : 0;
        else              r = va >>> b;
      end
      6: r = (va < vb) ? 1 : 0;
      default: begin r = va * vb; ovf = (r < lo) || (r > hi); end
    endcase
    y = r[W-1:0];
  endfunction

  txn_t mt;
  exp_t me;
  exp_t mg;
  logic [W-1:0] ma;
  logic [W-1:0] my;
  bit           mo;

  // Scoreboard and model: a transaction accepted at one edge computes at the
  // next edge on which the pipe advances, reading/updating the lane accumulators.
  always @(negedge clk) begin
    if (reset) begin
      pend.delete();
      sb.delete();
      for (int l = 0; l < LANES; l++) macc[l] = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got y=%0h, expected no output", out_y);
        end else begin
          mg = sb.pop_front();
          check("out_y", out_y, mg.y);
          check("out_ovf", out_ovf, mg.ovf);
        end
        obs_y.push_back(out_y[W-1:0]);
        obs_ovf.push_back(out_ovf[0]);
        obs_cyc.push_back(cyc);
      end
      if (in_ready && pend.size() > 0) begin
        mt = pend.pop_front();
        for (int l = 0; l < LANES; l++) begin
          ma = mt.acc ? macc[l] : mt.a[l*W +: W];
          ref_lane(ma, mt.b[l*W +: W], mt.op, mt.sgn, my, mo);
          me.y[l*W +: W] = my;
          me.ovf[l]      = mo;
        end
        sb.push_back(me);
        if (mt.acc) for (int l = 0; l < LANES; l++) macc[l] = me.y[l*W +: W];
      end
      if (acc_clr) for (int l = 0; l < LANES; l++) macc[l] = '0;
      if (in_valid && in_ready) begin
        mt.a   = in_a;
        mt.b   = in_b;
        mt.op  = int'(in_op);
        mt.sgn = in_signed;
        mt.acc = in_acc;
        pend.push_back(mt);
      end
    end
  end

  function automatic logic [BW-1:0] lane0(input logic [W-1:0] v);
    logic [BW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*W +: W] = W'($urandom);
    r[W-1:0] = v;
    return r;
  endfunction

  function automatic logic [W-1:0] obs_at(input int i);
    if (i < obs_y.size()) return obs_y[i];
    return 'x;
  endfunction

  function automatic logic obs_ovf_at(input int i);
    if (i < obs_ovf.size()) return obs_ovf[i];
    return 1'bx;
  endfunction

  task automatic clear_obs();
    obs_y.delete();
    obs_ovf.delete();
    obs_cyc.delete();
  endtask

  task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b, input int op,
                      input bit sgn, input bit acc);
    bit got = 0;
    in_a      = a;
    in_b      = b;
    in_op     = op[2:0];
    in_signed = sgn;
    in_acc    = acc;
    in_valid  = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && pend.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size() + pend.size());
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           op;
    bit           sgn;
    logic [W-1:0] y;
    bit           ovf;
  } dir_t;

  dir_t dir[$];
  logic [BW-1:0] held_y;
  int issued;
  bit accepted;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_signed = 1'b0;
    in_acc    = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed single-operation cases on lane 0
    dir.push_back('{6'd31,   6'd1, 0, 1'b1, 6'h20, 1'b1});
    dir.push_back('{6'd63,   6'd1, 0, 1'b0, 6'h00, 1'b1});
    dir.push_back('{6'd10,   6'd5, 0, 1'b0, 6'd15,  1'b0});
    dir.push_back('{6'h20,   6'd2, 5, 1'b1, 6'h38, 1'b0});
    dir.push_back('{6'h20,   6'd9, 5, 1'b1, 6'h3F, 1'b0});
    dir.push_back('{6'h20,   6'd2, 5, 1'b0, 6'h08, 1'b0});
    dir.push_back('{6'h20,   6'd6, 4, 1'b0, 6'h00, 1'b0});
    dir.push_back('{6'd9,    6'd7, 7, 1'b0, 6'd63,  1'b0});
    dir.push_back('{6'd9,    6'd8, 7, 1'b0, 6'd8,   1'b1});
    dir.push_back('{6'h3F,   6'd1, 6, 1'b1, 6'd1,   1'b0});
    dir.push_back('{6'h3F,   6'd1, 6, 1'b0, 6'd0,   1'b0});
    clear_obs();
    foreach (dir[i]) send(lane0(dir[i].a), lane0(dir[i].b), dir[i].op, dir[i].sgn, 1'b0);
    drain();
    foreach (dir[i]) begin
      check($sformatf("dir%0d_y", i), obs_at(i), dir[i].y);
      check($sformatf("dir%0d_ovf", i), obs_ovf_at(i), dir[i].ovf);
    end

    // Accumulator chain with clear colliding with the fourth write
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    clear_obs();
    repeat (4) send(lane0(6'd0), lane0(6'd5), 0, 1'b0, 1'b1);
    acc_clr = 1'b1;
    send(lane0(6'd0), lane0(6'd5), 0, 1'b0, 1'b1);
    acc_clr = 1'b0;
    drain();
    check("acc_out0", obs_at(0), 6'd5);
    check("acc_out1", obs_at(1), 6'd10);
    check("acc_out2", obs_at(2), 6'd15);
    check("acc_out3_clr", obs_at(3), 6'd20);
    check("acc_out4_after_clr", obs_at(4), 6'd5);
    if (obs_cyc.size() >= 3) begin
      check("acc_b2b_gap1", obs_cyc[1] - obs_cyc[0], 1);
      check("acc_b2b_gap2", obs_cyc[2] - obs_cyc[1], 1);
    end else begin
      check("acc_b2b_count", obs_cyc.size(), 3);
    end

    // Backpressure: two accepted, third held off until out_ready returns
    clear_obs();
    out_ready = 1'b0;
    send(lane0(6'd1), lane0(6'd0), 0, 1'b0, 1'b0);
    send(lane0(6'd2), lane0(6'd0), 0, 1'b0, 1'b0);
    in_a      = lane0(6'd3);
    in_b      = lane0(6'd0);
    in_op     = 3'd0;
    in_signed = 1'b0;
    in_acc    = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) held_y = out_y;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_y_stable", out_y, held_y);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(lane0(6'd3), lane0(6'd0), 0, 1'b0, 1'b0);
    drain();
    check("bp_count", obs_y.size(), 3);
    check("bp_order0", obs_at(0), 6'd1);
    check("bp_order1", obs_at(1), 6'd2);
    check("bp_order2", obs_at(2), 6'd3);

    // Reset with both stages full and output stalled
    out_ready = 1'b0;
    send(lane0(6'd7), lane0(6'd7), 0, 1'b0, 1'b1);
    send(lane0(6'd8), lane0(6'd8), 0, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_y", out_y, 0);
    check("rst2_out_ovf", out_ovf, 0);
    check("rst2_in_ready", in_ready, 1);
    out_ready = 1'b1;
    clear_obs();
    send(lane0(6'd0), lane0(6'd3), 0, 1'b0, 1'b1);
    drain();
    check("rst2_acc_add", obs_at(0), 6'd3);

    // Randomized traffic with random backpressure and accumulator clears
    issued   = 0;
    in_valid = 1'b0;
    accepted = 1'b0;
    for (int c = 0; c < 3000 && issued < 300; c++) begin
      out_ready = ($urandom % 4) != 0;
      acc_clr   = ($urandom % 16) == 0;
      if (!in_valid || accepted) begin
        in_valid  = ($urandom % 4) != 0;
        in_op     = 3'($urandom % 8);
        in_signed = 1'($urandom % 2);
        in_acc    = ($urandom % 3) == 0;
        for (int l = 0; l < LANES; l++) begin
          in_a[l*W +: W] = W'($urandom);
          in_b[l*W +: W] = ((in_op == 3'd4 || in_op == 3'd5) && ($urandom % 2 == 1))
                           ? W'($urandom % 8) : W'($urandom);
        end
      end
      @(negedge clk);
      accepted = in_valid && in_ready;
      if (accepted) issued++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    drain();
    check("rand_issued", issued, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/expr_lane_pipe.md
# expr_lane_pipe

Parametrised, pipelined multi-lane expression evaluator. Each transaction carries LANES independent W-bit operand pairs, one shared opcode and one shared signedness mode. The block returns a concatenated LANES*W result bus with per-lane overflow flags through a valid/ready pipeline. Each lane has an optional accumulator. It is the sequential, width/lane-generalised successor of the flat combinational expression blocks in the regression suite, and serves as a reusable datapath target for width, sign-extension and handshake checks.

## Interface
- LANES, 4: number of independent lanes (≥1)
- W, 6: lane width in bits (≥2)
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  transaction offered
- in_ready  out  1  block accepts when in_valid&&in_ready
- in_a  in  LANES*W  operand A, lane i at [i*W +: W]
- in_b  in  LANES*W  operand B, same packing
- in_op  in  3  opcode (see Operation)
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_acc  in  1  1 = lane accumulator replaces A
- acc_clr  in  1  synchronous clear of all accumulators
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_y  out  LANES*W  results, same packing
- out_ovf  out  LANES  per-lane overflow flag

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 XNOR (bitwise ~^), 4 SHL (A<<B), 5 SHR (A>>>B when signed, A>>B when unsigned), 6 LT (A<B), 7 MUL (low W bits of A*B).
- Compute at W+1 (ADD/SUB) or 2W (MUL) bits. Extension follows in_signed: sign-extend when set, zero-extend when clear. Truncate the result to W bits.
- ovf: ADD/SUB signed = true result outside [−2^(W−1), 2^(W−1)−1]; ADD/SUB unsigned = carry out or borrow. MUL = full product does not fit in W bits under the active signedness. All other ops: ovf=0.
- Shifts: B is always an unsigned shift amount. If B ≥ W, SHL gives 0 and SHR gives all-sign-bits (signed) or 0 (unsigned).
- LT: result is 1 or 0, zero-extended to W bits. Compare is signed or unsigned per in_signed.
- Accumulate: with in_acc=1, lane A := acc[i] at compute time. Every transaction with in_acc=1 writes its truncated result into acc[i] when it enters stage 2. Transactions with in_acc=0 leave acc untouched.
- acc_clr zeroes all acc[i] in the same cycle. It has priority over a simultaneous accumulator write; that transaction's out_y is still its computed value.

## Timing
- Stage 1 registers operands, op, mode and acc flag. Stage 2 registers results and ovf. Latency is 2 cycles from accept to out_valid.
- Throughput is 1 transaction per cycle while out_ready=1.
- Advance enable: en = !(v2 && !out_ready). in_ready = en, so a stalled output blocks input even if stage 1 is empty.
- When en=0, all stage registers and accumulators hold. out_y and out_ovf stay stable while out_valid && !out_ready.
- Back-to-back accumulate transactions see each other's updates with no bubble, because the accumulator is written on the same edge as stage 2.
- Order is strictly FIFO. No transaction is dropped or duplicated.
- Reset (any cycle, including mid-stall): v1=v2=0, out_valid=0, out_y=0, out_ovf=0, acc=0, in_ready=1 in the following cycle. In-flight transactions are discarded.

## Structure
- Package expr_lane_pkg: opcode enum (OP_ADD..OP_MUL), width of in_op, default LANES/W constants.
- Sub-module expr_lane_alu: combinational, one lane. Inputs a, b, op, signed; outputs y[W], ovf. Instantiated LANES times by a generate loop.
- The top level holds the pipeline valid bits, stage registers, accumulators and handshake logic.

## Test plan
- ADD, W=6, lane 0: signed 31+1 → y=6'h20, ovf=1. Unsigned 63+1 → y=0, ovf=1. Unsigned 10+5 → 15, ovf=0.
- SHR signed, A=6'h20 (−32): B=2 → 6'h38; B=9 → 6'h3F. Same A unsigned, B=2 → 6'h08. SHL by 6 → 0.
- MUL unsigned: 9*7 → 63, ovf=0; 9*8 → 8, ovf=1. LT, A=6'h3F, B=1: signed → 1, unsigned → 0.
- Accumulate: acc_clr, then three ADD with in_acc=1, B=5, issued back-to-back → outputs 5, 10, 15 on consecutive cycles. Then acc_clr coinciding with a fourth ADD → output 20, next accumulate ADD B=5 → 5.
- Backpressure: out_ready=0, offer 3 transactions → 2 accepted, in_ready=0 from cycle 2, out_y stable. Release out_ready → results emerge in issue order, third accepted.
- Reset asserted with both stages full and out_ready=0 → next cycle out_valid=0, out_y=0, in_ready=1. A subsequent accumulate ADD B=3 → 3.
